// File: rtl/execute_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : execute_pipe_if
// Purpose  : ID-to-execute issue bus and execute-to-writeback retire bus.
// Revision : 1.0
// ============================================================================
interface execute_pipe_if #(
    parameter int WORD  = 32,
    parameter int W_RD  = 5,
    parameter int W_OPC = 4
) ();
    logic             v_i;
    logic             stall_o;
    logic             flush_i;
    logic [W_OPC-1:0] opc_i;
    logic [WORD-1:0]  src_i;
    logic [WORD-1:0]  dest_i;
    logic             wb_i;
    logic             setf_i;
    logic [W_RD-1:0]  rd_num_i;
    logic             v_o;
    logic             wb_o;
    logic [W_RD-1:0]  rd_num_o;
    logic [WORD-1:0]  rd_data_o;
    logic [3:0]       status_o;

    modport master (
        output v_i, flush_i, opc_i, src_i, dest_i, wb_i, setf_i, rd_num_i,
        input  stall_o, v_o, wb_o, rd_num_o, rd_data_o, status_o
    );

    modport slave (
        input  v_i, flush_i, opc_i, src_i, dest_i, wb_i, setf_i, rd_num_i,
        output stall_o, v_o, wb_o, rd_num_o, rd_data_o, status_o
    );
endinterface
`default_nettype wire

// File: rtl/execute_pipe.sv
`default_nettype none
// ============================================================================
// Module   : execute_pipe
// Purpose  : Execute stage with single-cycle ALU, iterative shift-add MUL,
//            flush and NZCV status register.
// Revision : 1.0
// ============================================================================
module execute_pipe #(
    parameter int WORD  = 32,
    parameter int W_RD  = 5,
    parameter int W_OPC = 4,
    parameter int W_CNT = $clog2(WORD)
) (
    input  logic             clk,
    input  logic             rst,
    execute_pipe_if.slave    bus
);
    localparam logic [W_OPC-1:0] C_OP_ADD = W_OPC'(0);
    localparam logic [W_OPC-1:0] C_OP_SUB = W_OPC'(1);
    localparam logic [W_OPC-1:0] C_OP_AND = W_OPC'(2);
    localparam logic [W_OPC-1:0] C_OP_OR  = W_OPC'(3);
    localparam logic [W_OPC-1:0] C_OP_XOR = W_OPC'(4);
    localparam logic [W_OPC-1:0] C_OP_SLL = W_OPC'(5);
    localparam logic [W_OPC-1:0] C_OP_SRL = W_OPC'(6);
    localparam logic [W_OPC-1:0] C_OP_SRA = W_OPC'(7);
    localparam logic [W_OPC-1:0] C_OP_MUL = W_OPC'(8);
    localparam logic [W_OPC-1:0] C_OP_CMP = W_OPC'(9);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           state_q;
    logic             v_q;
    logic             wb_q;
    logic [W_RD-1:0]  rd_num_q;
    logic [WORD-1:0]  rd_data_q;
    logic [3:0]       status_q;
    logic [WORD-1:0]  acc_q;
    logic [WORD-1:0]  mcand_q;
    logic [WORD-1:0]  mplier_q;
    logic [W_CNT-1:0] cnt_q;
    logic [W_RD-1:0]  mul_rd_q;
    logic             mul_wb_q;
    logic             mul_setf_q;

    logic [WORD-1:0]  a;
    logic [WORD-1:0]  b;
    logic [W_CNT-1:0] shamt;
    logic             accept;
    logic [WORD:0]    add_w;
    logic [WORD:0]    sub_w;
    logic [WORD:0]    sll_w;
    logic [WORD:0]    srl_w;
    logic [WORD:0]    sra_w;
    logic [WORD-1:0]  alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_wb;
    logic             alu_flags_ok;
    logic [WORD-1:0]  acc_d;

    assign a      = bus.dest_i;
    assign b      = bus.src_i;
    assign shamt  = b[W_CNT-1:0];
    assign accept = bus.v_i & ~bus.stall_o & ~bus.flush_i;

    // Shifts run one bit wider so the last bit shifted out lands in the
    // extra position; a zero shift leaves that position 0.
    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} + {1'b0, ~b} + {{WORD{1'b0}}, 1'b1};
    assign sll_w = {1'b0, a} << shamt;
    assign srl_w = {a, 1'b0} >> shamt;
    assign sra_w = $signed({a, 1'b0}) >>> shamt;

    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : {WORD{1'b0}});

    always_comb begin
        alu_res      = '0;
        alu_c        = 1'b0;
        alu_v        = 1'b0;
        alu_wb       = bus.wb_i;
        alu_flags_ok = 1'b1;
        case (bus.opc_i)
            C_OP_ADD: begin
                alu_res = add_w[WORD-1:0];
                alu_c   = add_w[WORD];
                alu_v   = (a[WORD-1] == b[WORD-1]) && (alu_res[WORD-1] != a[WORD-1]);
            end
            C_OP_SUB, C_OP_CMP: begin
                alu_res = sub_w[WORD-1:0];
                alu_c   = sub_w[WORD];
                alu_v   = (a[WORD-1] != b[WORD-1]) && (alu_res[WORD-1] != a[WORD-1]);
                if (bus.opc_i == C_OP_CMP) begin
                    alu_wb = 1'b0;
                end
            end
            C_OP_AND: alu_res = a & b;
            C_OP_OR:  alu_res = a | b;
            C_OP_XOR: alu_res = a ^ b;
            C_OP_SLL: begin
                alu_res = sll_w[WORD-1:0];
                alu_c   = sll_w[WORD];
            end
            C_OP_SRL: begin
                alu_res = srl_w[WORD:1];
                alu_c   = srl_w[0];
            end
            C_OP_SRA: begin
                alu_res = sra_w[WORD:1];
                alu_c   = sra_w[0];
            end
            default: begin
                alu_wb       = 1'b0;
                alu_flags_ok = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            v_q        <= 1'b0;
            wb_q       <= 1'b0;
            rd_num_q   <= '0;
            rd_data_q  <= '0;
            status_q   <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            mul_rd_q   <= '0;
            mul_wb_q   <= 1'b0;
            mul_setf_q <= 1'b0;
        end else begin
            v_q  <= 1'b0;
            wb_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept && bus.opc_i == C_OP_MUL) begin
                        state_q    <= S_MUL;
                        mcand_q    <= a;
                        mplier_q   <= b;
                        acc_q      <= '0;
                        cnt_q      <= W_CNT'(WORD - 1);
                        mul_rd_q   <= bus.rd_num_i;
                        mul_wb_q   <= bus.wb_i;
                        mul_setf_q <= bus.setf_i;
                    end else if (accept) begin
                        v_q       <= 1'b1;
                        wb_q      <= alu_wb;
                        rd_num_q  <= bus.rd_num_i;
                        rd_data_q <= alu_res;
                        if (bus.setf_i && alu_flags_ok) begin
                            status_q <= {alu_res[WORD-1], (alu_res == '0), alu_c, alu_v};
                        end
                    end
                end
                S_MUL: begin
                    // A flush beats the final step: the product is dropped.
                    if (bus.flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            state_q   <= S_IDLE;
                            v_q       <= 1'b1;
                            wb_q      <= mul_wb_q;
                            rd_num_q  <= mul_rd_q;
                            rd_data_q <= acc_d;
                            if (mul_setf_q) begin
                                status_q <= {acc_d[WORD-1], (acc_d == '0), 2'b00};
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.stall_o   = (state_q == S_MUL);
    assign bus.v_o       = v_q;
    assign bus.wb_o      = wb_q;
    assign bus.rd_num_o  = rd_num_q;
    assign bus.rd_data_o = rd_data_q;
    assign bus.status_o  = status_q;
endmodule
`default_nettype wire

// File: tb/tb_execute_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_pipe
// Purpose  : Directed and randomized checks of execute_pipe against a
//            behavioural model.
// Revision : 1.0
// ============================================================================
module tb_execute_pipe;
    localparam int WORD = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    execute_pipe_if #(.WORD(WORD), .W_RD(5), .W_OPC(4)) bus ();

    execute_pipe #(.WORD(WORD), .W_RD(5), .W_OPC(4), .W_CNT(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference ALU from the arithmetic definitions of each operation.
    function automatic void ref_alu(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f, output bit ok);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint sr;
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        int n = int'(b[4:0]);
        bit c = 0;
        bit v = 0;
        ok = 1;
        r  = '0;
        case (opc)
            4'd0: begin
                r  = a + b;
                c  = (ua + ub) > 64'hFFFF_FFFF;
                sr = sa + sb;
                v  = (sr > MAXS) || (sr < MINS);
            end
            4'd1, 4'd9: begin
                r  = a - b;
                c  = (a >= b);
                sr = sa - sb;
                v  = (sr > MAXS) || (sr < MINS);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin
                r = a << n;
                c = (n == 0) ? 1'b0 : a[32-n];
            end
            4'd6: begin
                r = a >> n;
                c = (n == 0) ? 1'b0 : a[n-1];
            end
            4'd7: begin
                r = 32'($signed(a) >>> n);
                c = (n == 0) ? 1'b0 : a[n-1];
            end
            default: ok = 0;
        endcase
        f = {r[31], (r == 32'd0), c, v};
    endfunction

    // Behavioural model state
    int          mul_left = 0;
    logic [31:0] m_prod;
    logic [4:0]  m_rd;
    logic        m_wb, m_setf;
    logic        exp_v, exp_wb;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    bit          exp_data_ok;
    logic [3:0]  exp_status;

    always @(posedge clk) begin
        logic [31:0] r;
        logic [3:0]  f;
        bit          ok;
        if (!rst) begin
            mul_left = 0; exp_v = 0; exp_wb = 0; exp_rd = 0;
            exp_data = 0; exp_data_ok = 1; exp_status = 0;
        end else if (mul_left > 0) begin
            if (bus.flush_i) begin
                mul_left = 0; exp_v = 0; exp_wb = 0;
            end else begin
                mul_left--;
                exp_v = (mul_left == 0);
                exp_wb = (mul_left == 0) ? m_wb : 1'b0;
                if (mul_left == 0) begin
                    exp_rd = m_rd; exp_data = m_prod; exp_data_ok = 1;
                    if (m_setf) exp_status = {m_prod[31], (m_prod == 32'd0), 2'b00};
                end
            end
        end else if (bus.v_i && !bus.flush_i) begin
            if (bus.opc_i == 4'd8) begin
                mul_left = WORD;
                m_prod = bus.dest_i * bus.src_i;
                m_rd = bus.rd_num_i; m_wb = bus.wb_i; m_setf = bus.setf_i;
                exp_v = 0; exp_wb = 0;
            end else begin
                ref_alu(bus.opc_i, bus.dest_i, bus.src_i, r, f, ok);
                exp_v = 1;
                exp_wb = bus.wb_i && ok && (bus.opc_i != 4'd9);
                exp_rd = bus.rd_num_i;
                exp_data = r; exp_data_ok = ok;
                if (bus.setf_i && ok) exp_status = f;
            end
        end else begin
            exp_v = 0; exp_wb = 0;
        end
        #1;
        chk("v_o", 64'(bus.v_o), 64'(exp_v));
        chk("wb_o", 64'(bus.wb_o), 64'(exp_wb));
        chk("rd_num_o", 64'(bus.rd_num_o), 64'(exp_rd));
        if (exp_data_ok) chk("rd_data_o", 64'(bus.rd_data_o), 64'(exp_data));
        chk("status_o", 64'(bus.status_o), 64'(exp_status));
        chk("stall_o", 64'(bus.stall_o), 64'(mul_left > 0));
    end

    int vcount = 0;
    int rdlog[$];
    always @(negedge clk) begin
        if (bus.v_o === 1'b1) begin
            vcount++;
            rdlog.push_back(int'(bus.rd_num_o));
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [3:0] opc, input logic [31:0] d, input logic [31:0] s,
                        input logic wb, input logic setf, input logic [4:0] rd, output int waited);
        waited = 0;
        bus.v_i = 1; bus.opc_i = opc; bus.dest_i = d; bus.src_i = s;
        bus.wb_i = wb; bus.setf_i = setf; bus.rd_num_i = rd;
        while (bus.stall_o && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (bus.stall_o) begin
            total++; bad++;
            $display("FAIL send_timeout: stall_o still %0b after %0d cycles", bus.stall_o, waited);
        end
        @(negedge clk);
        bus.v_i = 0;
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int w, sc, vc, vi, v0;
        bus.v_i = 0; bus.flush_i = 0; bus.opc_i = 0; bus.src_i = 0; bus.dest_i = 0;
        bus.wb_i = 0; bus.setf_i = 0; bus.rd_num_i = 0;
        repeat (3) @(negedge clk);
        chk("rst_v", 64'(bus.v_o), 64'd0);
        chk("rst_stall", 64'(bus.stall_o), 64'd0);
        chk("rst_status", 64'(bus.status_o), 64'd0);
        chk("rst_data", 64'(bus.rd_data_o), 64'd0);
        rst = 1;
        @(negedge clk);

        send(4'd0, 32'h7FFF_FFFF, 32'd1, 1, 1, 5'd3, w);
        chk("add_v", 64'(bus.v_o), 64'd1);
        chk("add_wb", 64'(bus.wb_o), 64'd1);
        chk("add_rd", 64'(bus.rd_num_o), 64'd3);
        chk("add_data", 64'(bus.rd_data_o), 64'h8000_0000);
        chk("add_nzcv", 64'(bus.status_o), 64'b1001);

        send(4'd9, 32'd5, 32'd5, 1, 1, 5'd7, w);
        chk("cmp_wb", 64'(bus.wb_o), 64'd0);
        chk("cmp_nzcv", 64'(bus.status_o), 64'b0110);

        send(4'd7, 32'h8000_0000, 32'd4, 1, 1, 5'd4, w);
        chk("sra_data", 64'(bus.rd_data_o), 64'hF800_0000);
        chk("sra_nzcv", 64'(bus.status_o), 64'b1000);

        send(4'd8, 32'h0001_0003, 32'h0000_0005, 1, 1, 5'd9, w);
        sc = 0; vc = 0; vi = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.stall_o) sc++;
            if (bus.v_o) begin vc++; vi = i; end
            @(negedge clk);
        end
        chk("mul_stall_cycles", 64'(sc), 64'd32);
        chk("mul_v_pulses", 64'(vc), 64'd1);
        chk("mul_latency", 64'(vi), 64'd32);
        chk("mul_data", 64'(bus.rd_data_o), 64'h0005_000F);

        rdlog.delete();
        send(4'd8, 32'd3, 32'd7, 1, 0, 5'd10, w);
        send(4'd0, 32'd1, 32'd2, 1, 1, 5'd11, w);
        chk("held_add_wait", 64'(w), 64'd32);
        @(negedge clk);
        chk("b2b_count", 64'(rdlog.size()), 64'd2);
        if (rdlog.size() == 2) begin
            chk("b2b_first", 64'(rdlog[0]), 64'd10);
            chk("b2b_second", 64'(rdlog[1]), 64'd11);
        end

        send(4'd8, 32'h8000_0000, 32'd3, 1, 1, 5'd12, w);
        v0 = vcount;
        repeat (9) @(negedge clk);
        bus.flush_i = 1;
        @(negedge clk);
        bus.flush_i = 0;
        chk("flush10_stall", 64'(bus.stall_o), 64'd0);
        chk("flush10_v", 64'(bus.v_o), 64'd0);
        repeat (40) @(negedge clk);
        chk("flush10_no_retire", 64'(vcount - v0), 64'd0);
        chk("flush10_status", 64'(bus.status_o), 64'b0000);

        send(4'd8, 32'h8000_0000, 32'd3, 1, 1, 5'd12, w);
        v0 = vcount;
        repeat (31) @(negedge clk);
        chk("pre_flush_stall", 64'(bus.stall_o), 64'd1);
        bus.flush_i = 1;
        @(negedge clk);
        bus.flush_i = 0;
        chk("flushlast_stall", 64'(bus.stall_o), 64'd0);
        repeat (40) @(negedge clk);
        chk("flushlast_no_retire", 64'(vcount - v0), 64'd0);
        chk("flushlast_status", 64'(bus.status_o), 64'b0000);

        send(4'd8, 32'd7, 32'd9, 1, 1, 5'd13, w);
        repeat (5) @(negedge clk);
        rst = 0;
        #1;
        chk("rstmid_stall", 64'(bus.stall_o), 64'd0);
        chk("rstmid_rd", 64'(bus.rd_num_o), 64'd0);
        chk("rstmid_data", 64'(bus.rd_data_o), 64'd0);
        chk("rstmid_v", 64'(bus.v_o), 64'd0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        send(4'd0, 32'd10, 32'd20, 1, 1, 5'd5, w);
        chk("post_rst_v", 64'(bus.v_o), 64'd1);
        chk("post_rst_data", 64'(bus.rd_data_o), 64'd30);

        for (int k = 0; k < 3000; k++) begin
            if (!bus.stall_o) begin
                bus.v_i = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 9))
                    0:       bus.opc_i = 4'd8;
                    1:       bus.opc_i = 4'($urandom_range(10, 15));
                    2:       bus.opc_i = 4'd9;
                    default: bus.opc_i = 4'($urandom_range(0, 7));
                endcase
                bus.dest_i = rnd_word();
                bus.src_i = rnd_word();
                bus.wb_i = 1'($urandom_range(0, 1));
                bus.setf_i = 1'($urandom_range(0, 1));
                bus.rd_num_i = 5'($urandom);
            end
            bus.flush_i = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        bus.v_i = 0;
        bus.flush_i = 0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
